// File: rtl/subckt_test_sequencer_pkg.sv
// Shared types and constants for the subcircuit test sequencer.
// Holds the FSM state encoding, the signature width, the LFSR/MISR
// polynomial taps, their reset values and the single-step helper.
package subckt_test_pkg;

    localparam int SIG_W = 16;

    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
    localparam logic [SIG_W-1:0] POLY_TAPS = 16'hB400;

    localparam logic [SIG_W-1:0] LFSR_RST_VAL = 16'hACE1;
    localparam logic [SIG_W-1:0] MISR_RST_VAL = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DUT_RST = 3'd1,
        ST_APPLY   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    // One Fibonacci step, shifting left, with parallel data folded in.
    function automatic logic [SIG_W-1:0] poly_step(input logic [SIG_W-1:0] v,
                                                   input logic [SIG_W-1:0] d);
        return {v[SIG_W-2:0], ^(v & POLY_TAPS)} ^ d;
    endfunction

endpackage

// File: rtl/subckt_test_sequencer_if.sv
// Control/status and SUT-facing bundle of the test sequencer.
// master: the side that starts runs and returns SUT outputs.
// slave : the sequencer itself.
// Optional macro SUBCKT_TEST_STUCK_CHECK_EN adds the stuck_mask output.
interface subckt_test_sequencer_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 1
);
    logic             start;
    logic             abort;
    logic [15:0]      golden_sig;
    logic [OUT_W-1:0] dut_out;
    logic [IN_W-1:0]  dut_in;
    logic             dut_rst;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      signature;
`ifdef SUBCKT_TEST_STUCK_CHECK_EN
    logic [OUT_W-1:0] stuck_mask;

    modport master (
        output start, abort, golden_sig, dut_out,
        input  dut_in, dut_rst, busy, done, pass, signature, stuck_mask
    );
    modport slave (
        input  start, abort, golden_sig, dut_out,
        output dut_in, dut_rst, busy, done, pass, signature, stuck_mask
    );
`else
    modport master (
        output start, abort, golden_sig, dut_out,
        input  dut_in, dut_rst, busy, done, pass, signature
    );
    modport slave (
        input  start, abort, golden_sig, dut_out,
        output dut_in, dut_rst, busy, done, pass, signature
    );
`endif
endinterface

// File: rtl/subckt_test_sequencer_sig_lfsr16.sv
// 16-bit Fibonacci shift register used both as the pattern generator
// (data_in tied to zero) and as the output-compacting MISR.
// load has priority over step.
module sig_lfsr16
    import subckt_test_pkg::*;
#(
    parameter logic [SIG_W-1:0] RST_VAL = MISR_RST_VAL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [SIG_W-1:0] load_val,
    input  logic             step,
    input  logic [SIG_W-1:0] data_in,
    output logic [SIG_W-1:0] q
);

    logic [SIG_W-1:0] r_q;

    // Shift register: reload on run start/abort, otherwise advance on step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else if (load) begin
            r_q <= load_val;
        end else if (step) begin
            r_q <= poly_step(r_q, data_in);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/subckt_test_sequencer.sv
// Built-in test sequencer for one extracted subcircuit instance.
// Holds the SUT in reset, streams LFSR patterns into it, compacts the
// settled outputs into a MISR and compares against a golden signature.
// Optional macro SUBCKT_TEST_STUCK_CHECK_EN adds per-bit toggle tracking
// and the stuck_mask output; without it pass is the signature compare only.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start; dut_in shows the seed pattern
//   DUT_RST  | SUT reset held for two cycles
//   APPLY    | pattern held SETTLE+1 cycles, captured on the last one
//   COMPARE  | one cycle, pass registered from the final signature
//   DONE     | done high, signature/pass held until the next start
module subckt_test_sequencer
    import subckt_test_pkg::*;
#(
    parameter int               IN_W    = 8,
    parameter int               OUT_W   = 1,
    parameter int               PAT_CNT = 256,
    parameter int               SETTLE  = 3,
    parameter logic [SIG_W-1:0] SEED    = LFSR_RST_VAL
) (
    input logic                    I1294,
    input logic                    I1301,
    subckt_test_sequencer_if.slave bus
);

    localparam logic [3:0]  SETTLE_L = 4'(SETTLE);
    localparam logic [15:0] LAST_PAT = 16'(PAT_CNT - 1);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [3:0]       r_phase;
    logic [15:0]      r_pat_cnt;
    logic             r_rst_cnt;
    logic             r_abort_rst;
    logic             r_pass;

    logic             w_busy;
    logic             w_done;
    logic             w_dut_rst;
    logic             w_start_ok;
    logic             w_abort;
    logic             w_capture;
    logic             w_last;
    logic             w_pass_cond;
    logic [SIG_W-1:0] w_lfsr_q;
    logic [SIG_W-1:0] w_misr_q;
    logic [SIG_W-1:0] w_misr_din;
    logic             w_unused_lfsr;

    assign w_start_ok = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_abort    = bus.abort && (r_state == ST_DUT_RST || r_state == ST_APPLY ||
                                      r_state == ST_COMPARE);
    // Abort suppresses the capture so the partial signature is left untouched.
    assign w_capture  = (r_state == ST_APPLY) && (r_phase == SETTLE_L) && !w_abort;
    assign w_last     = (r_pat_cnt == LAST_PAT);

    // Zero-extend the SUT outputs into the MISR data word.
    always_comb begin
        w_misr_din              = '0;
        w_misr_din[OUT_W-1:0]   = bus.dut_out;
    end

    sig_lfsr16 #(.RST_VAL(SEED)) u_gen (
        .clock    (I1294),
        .reset    (I1301),
        .load     (w_start_ok || w_abort),
        .load_val (SEED),
        .step     (w_capture),
        .data_in  ('0),
        .q        (w_lfsr_q)
    );

    // The MISR is only cleared by a new run; abort leaves the partial value.
    sig_lfsr16 #(.RST_VAL(MISR_RST_VAL)) u_misr (
        .clock    (I1294),
        .reset    (I1301),
        .load     (w_start_ok),
        .load_val (MISR_RST_VAL),
        .step     (w_capture),
        .data_in  (w_misr_din),
        .q        (w_misr_q)
    );

    assign w_unused_lfsr = ^w_lfsr_q;

    // FSM state register.
    always_ff @(posedge I1294 or posedge I1301) begin
        if (I1301) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; abort overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (bus.start) w_state_nxt = ST_DUT_RST;
                ST_DUT_RST: if (r_rst_cnt) w_state_nxt = ST_APPLY;
                ST_APPLY:   if (w_capture && w_last) w_state_nxt = ST_COMPARE;
                ST_COMPARE: w_state_nxt = ST_DONE;
                ST_DONE:    if (bus.start) w_state_nxt = ST_DUT_RST;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs; the SUT also sees reset whenever the sequencer is in reset.
    always_comb begin
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_dut_rst = I1301 || r_abort_rst;
        case (r_state)
            ST_DUT_RST: begin
                w_busy    = 1'b1;
                w_dut_rst = 1'b1;
            end
            ST_APPLY:   w_busy = 1'b1;
            ST_COMPARE: w_busy = 1'b1;
            ST_DONE:    w_done = 1'b1;
            default:    ;
        endcase
    end

    // Sequencing counters: SUT reset length, settle phase and pattern index.
    always_ff @(posedge I1294 or posedge I1301) begin
        if (I1301) begin
            r_rst_cnt   <= 1'b0;
            r_phase     <= '0;
            r_pat_cnt   <= '0;
            r_abort_rst <= 1'b0;
        end else begin
            r_rst_cnt   <= (r_state == ST_DUT_RST) && !r_rst_cnt && !w_abort;
            r_abort_rst <= w_abort;
            if (r_state != ST_APPLY || w_capture || w_abort) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 4'd1;
            end
            if (w_start_ok || w_abort) begin
                r_pat_cnt <= '0;
            end else if (w_capture) begin
                r_pat_cnt <= r_pat_cnt + 16'd1;
            end
        end
    end

`ifdef SUBCKT_TEST_STUCK_CHECK_EN
    logic [OUT_W-1:0] r_prev_out;
    logic [OUT_W-1:0] r_toggled;
    logic [OUT_W-1:0] r_stuck_mask;

    // Toggle tracking: compare each capture with the previous one of the run.
    always_ff @(posedge I1294 or posedge I1301) begin
        if (I1301) begin
            r_prev_out   <= '0;
            r_toggled    <= '0;
            r_stuck_mask <= '0;
        end else if (w_start_ok || w_abort) begin
            r_toggled    <= '0;
            r_stuck_mask <= '0;
        end else if (w_capture) begin
            if (r_pat_cnt != 16'd0) begin
                r_toggled <= r_toggled | (r_prev_out ^ bus.dut_out);
            end
            r_prev_out <= bus.dut_out;
        end else if (r_state == ST_COMPARE) begin
            r_stuck_mask <= ~r_toggled;
        end
    end

    assign w_pass_cond    = (w_misr_q == bus.golden_sig) && (&r_toggled);
    assign bus.stuck_mask = r_stuck_mask;
`else
    assign w_pass_cond    = (w_misr_q == bus.golden_sig);
`endif

    // Pass verdict: cleared by a new run or abort, registered in COMPARE.
    always_ff @(posedge I1294 or posedge I1301) begin
        if (I1301) begin
            r_pass <= 1'b0;
        end else if (w_start_ok || w_abort) begin
            r_pass <= 1'b0;
        end else if (r_state == ST_COMPARE) begin
            r_pass <= w_pass_cond;
        end
    end

    assign bus.dut_in    = w_lfsr_q[IN_W-1:0];
    assign bus.dut_rst   = w_dut_rst;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.pass      = r_pass;
    assign bus.signature = w_misr_q;

endmodule
